// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package s2p_pkg;

    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit counter width; one bit minimum so a single-bit word still has a legal counter.
    function automatic int unsigned cnt_width(input int unsigned dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/s2p_hold.sv
// Output holding register: valid/ready handshake, overrun detection on a full, stalled register.
module s2p_hold
    import s2p_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          word_vld,
    input  logic [DW-1:0] word,
    input  logic          dout_rdy,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          overrun
);

    logic [DW-1:0] dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            overrun_q  <= overrun_d;
        end
    end

    // A new word may enter when the register is empty or draining on this same edge.
    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        overrun_d  = 1'b0;
        if (word_vld && (!dout_vld_q || dout_rdy)) begin
            dout_d     = word;
            dout_vld_d = 1'b1;
        end else if (dout_vld_q && dout_rdy) begin
            dout_vld_d = 1'b0;
        end
        if (word_vld && dout_vld_q && !dout_rdy) begin
            overrun_d = 1'b1;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: LSB-first bits framed by sof, assembled into DW-bit words.
module s2p
    import s2p_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_vld,
    input  logic          sof,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          overrun,
    output logic          frame_err
);

    localparam int unsigned CW       = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          done_q, done_d;
    logic          frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next state: sof always restarts a cleared word at bit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (din_vld) begin
            unique case (state_q)
                IDLE: begin
                    if (sof) begin
                        shift_d    = '0;
                        shift_d[0] = din;
                        if (DW > 1) begin
                            cnt_d   = CW'(1);
                            state_d = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (sof) begin
                        shift_d    = '0;
                        shift_d[0] = din;
                        cnt_d      = CW'(1);
                    end else begin
                        shift_d[cnt_q] = din;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion and framing-error strobes, registered; shift_q holds the full word while done_q is set.
    always_comb begin
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        if (din_vld) begin
            unique case (state_q)
                IDLE:    done_d = sof && (DW == 1);
                SHIFT: begin
                    frame_err_d = sof;
                    done_d      = !sof && (cnt_q == CNT_LAST);
                end
                default: ;
            endcase
        end
    end

    assign frame_err = frame_err_q;

    s2p_hold #(
        .DW (DW)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .word_vld (done_q),
        .word     (shift_q),
        .dout_rdy (dout_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_s2p.sv
// Directed self-checking bench for s2p (DW=8).
module tb_s2p;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_vld;
    logic       sof;
    logic [7:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       overrun;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    // Observations gathered at the falling edge
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] got[$];

    s2p #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .sof       (sof),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (dout_vld === 1'b1 && dout_rdy === 1'b1) got.push_back(dout);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic s, input logic b);
        din_vld = 1'b1;
        sof     = s;
        din     = b;
        tick();
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        sof     = 1'b0;
        din     = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(i == 0, w[i]);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        din      = 1'b0;
        din_vld  = 1'b0;
        sof      = 1'b0;
        dout_rdy = 1'b0;
        repeat (2) tick();
        total++; if (dout !== 8'h00)   begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_dout_vld: got %b want 0", dout_vld); end
        total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int base = got.size();
        int fe0  = fe_cnt;
        int ov0  = ov_cnt;
        dout_rdy = 1'b1;
        send_word(8'hDC);
        total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL b2b_latency: dout_vld got %b want 0 at last-bit edge", dout_vld); end
        idle(1);
        total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld: got %b want 1", dout_vld); end
        total++; if (dout !== 8'hDC)    begin bad++; $display("FAIL b2b_dout: got %h want dc", dout); end
        idle(1);
        total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL b2b_vld_drop: got %b want 0", dout_vld); end
        total++; if (got.size() - base !== 1) begin bad++; $display("FAIL b2b_count: got %0d want 1", got.size() - base); end
        total++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin bad++; $display("FAIL b2b_flags: got %0d want 0", fe_cnt - fe0 + ov_cnt - ov0); end
    endtask

    task automatic test_gapped();
        logic [7:0] w = 8'hDC;
        int base = got.size();
        int fe0  = fe_cnt;
        int ov0  = ov_cnt;
        dout_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0, w[i]);
            idle(1);
        end
        idle(3);
        total++; if (got.size() - base !== 1) begin bad++; $display("FAIL gap_count: got %0d want 1", got.size() - base); end
        else begin
            total++; if (got[base] !== 8'hDC) begin bad++; $display("FAIL gap_word: got %h want dc", got[base]); end
        end
        total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL gap_frame_err: got %0d want 0", fe_cnt - fe0); end
        total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL gap_overrun: got %0d want 0", ov_cnt - ov0); end
    endtask

    task automatic test_resync();
        int base = got.size();
        int fe0  = fe_cnt;
        dout_rdy = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_word(8'hA5);
        idle(3);
        total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL resync_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
        total++; if (got.size() - base !== 1) begin bad++; $display("FAIL resync_count: got %0d want 1", got.size() - base); end
        else begin
            total++; if (got[base] !== 8'hA5) begin bad++; $display("FAIL resync_word: got %h want a5", got[base]); end
        end
        total++; if (dout !== 8'hA5 || dout_vld !== 1'b0) begin bad++; $display("FAIL resync_hold_last: got %h/%b want a5/0", dout, dout_vld); end
    endtask

    task automatic test_backpressure();
        int base = got.size();
        int ov0  = ov_cnt;
        dout_rdy = 1'b0;
        send_word(8'h3C);
        idle(2);
        total++; if (dout !== 8'h3C || dout_vld !== 1'b1) begin bad++; $display("FAIL bp_held: got %h/%b want 3c/1", dout, dout_vld); end
        send_word(8'hC3);
        idle(3);
        total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL bp_overrun: got %0d pulses want 1", ov_cnt - ov0); end
        total++; if (dout !== 8'h3C || dout_vld !== 1'b1) begin bad++; $display("FAIL bp_stable: got %h/%b want 3c/1", dout, dout_vld); end
        dout_rdy = 1'b1;
        idle(3);
        total++; if (got.size() - base !== 1) begin bad++; $display("FAIL bp_count: got %0d want 1", got.size() - base); end
        else begin
            total++; if (got[base] !== 8'h3C) begin bad++; $display("FAIL bp_word: got %h want 3c", got[base]); end
        end
        total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", dout_vld); end
    endtask

    task automatic test_collision();
        int base = got.size();
        int ov0  = ov_cnt;
        dout_rdy = 1'b0;
        send_word(8'h3C);
        idle(2);
        send_word(8'hC3);
        dout_rdy = 1'b1;
        idle(1);
        total++; if (dout !== 8'hC3 || dout_vld !== 1'b1) begin bad++; $display("FAIL coll_load: got %h/%b want c3/1", dout, dout_vld); end
        total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL coll_overrun: got %0d want 0", ov_cnt - ov0); end
        idle(2);
        total++; if (got.size() - base !== 2) begin bad++; $display("FAIL coll_count: got %0d want 2", got.size() - base); end
        else begin
            total++; if (got[base] !== 8'h3C || got[base+1] !== 8'hC3) begin bad++; $display("FAIL coll_order: got %h,%h want 3c,c3", got[base], got[base+1]); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        dout_rdy = 1'b1;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        din_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        total++; if (dout !== 8'h00 || dout_vld !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL rstmid_async: got %h/%b/%b/%b want 00/0/0/0", dout, dout_vld, overrun, frame_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        base = got.size();
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        idle(3);
        total++; if (got.size() - base !== 0 || dout_vld !== 1'b0) begin bad++; $display("FAIL rstmid_ignore: got %0d words vld %b want 0/0", got.size() - base, dout_vld); end
        send_word(8'h01);
        idle(1);
        total++; if (dout !== 8'h01) begin bad++; $display("FAIL rstmid_word: got %h want 01", dout); end
        idle(2);
        total++; if (got.size() - base !== 1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", got.size() - base); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_resync();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s2p.md
S2P -- requirements
Module: s2p

Interface
REQ-001 SHALL have parameter: DW, 8, deserialized word width (DW >= 1).
REQ-002 SHALL have port: clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: din  input  1  serial data bit, LSB of each word first.
REQ-005 SHALL have port: din_vld  input  1  din qualifier; one bit consumed per clk with din_vld=1.
REQ-006 SHALL have port: sof  input  1  start-of-frame; meaningful only with din_vld=1; marks the bit as word bit 0.
REQ-007 SHALL have port: dout  output  DW  assembled parallel word.
REQ-008 SHALL have port: dout_vld  output  1  dout holds a valid word.
REQ-009 SHALL have port: dout_rdy  input  1  consumer accepts; transfer when dout_vld && dout_rdy.
REQ-010 SHALL have port: overrun  output  1  one-cycle pulse; completed word dropped.
REQ-011 SHALL have port: frame_err  output  1  one-cycle pulse; partial word discarded by new sof.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT plus bit counter cnt, width clog2(DW), max 1 for DW=1.
REQ-013 IDLE: din_vld && !sof SHALL be ignored; din_vld && sof SHALL write din to shift bit 0, set cnt=1, go to SHIFT (DW>1).
REQ-014 SHIFT: din_vld && !sof SHALL write din to shift bit cnt and increment cnt; din_vld=0 SHALL hold all state (no timeout).
REQ-015 Word completes in the cycle bit DW-1 is sampled; FSM SHALL return to IDLE with cnt=0 next edge.
REQ-016 DW=1: sof bit SHALL complete a word immediately; FSM stays in IDLE.
REQ-017 SHIFT with din_vld && sof: frame_err SHALL pulse next cycle, partial bits discarded, din taken as bit 0 of a new word, cnt=1.
REQ-018 Bits not yet written in a word SHALL not leak from a previous word (cleared at sof).
REQ-019 On completion, word SHALL load into the holding register if empty, or if dout_vld && dout_rdy in the same cycle; dout_vld=1 from the next cycle.
REQ-020 Latency: last bit sampled at edge N -> dout/dout_vld valid after edge N+1 (one clock).
REQ-021 On completion with holding register full and not draining: new word SHALL be dropped, held word unchanged, overrun pulses one cycle.
REQ-022 dout SHALL stay stable while dout_vld && !dout_rdy; dout_vld SHALL clear after transfer unless a new word loads the same edge.
REQ-023 dout SHALL keep its last value after dout_vld drops (no clear on drain).

Reset
REQ-024 rst_n=0 SHALL asynchronously force: FSM=IDLE, cnt=0, shift=0, dout=0, dout_vld=0, overrun=0, frame_err=0.
REQ-025 Reset mid-word SHALL discard the partial word; after release, bits before the next sof SHALL be ignored.
REQ-026 Outputs SHALL be registered; no combinational path from inputs to outputs.

Structure
REQ-027 Package s2p_pkg SHALL hold the FSM state enum typedef and default DW constant.
REQ-028 Output holding register with valid/ready and overrun logic SHALL be sub-module s2p_hold; FSM/shift/counter stay in s2p.

Verification
REQ-029 Back-to-back: sof + 0xDC bits 0,0,1,1,1,0,1,1 on 8 consecutive cycles, dout_rdy=1 -> dout=0xDC, dout_vld high exactly 1 cycle, one clk after 8th bit.
REQ-030 Gapped: same 0xDC with din_vld low every other cycle -> dout=0xDC once, no frame_err/overrun.
REQ-031 Resync: sof + 3 bits, then sof + 0xA5 -> frame_err one pulse; only 0xA5 delivered.
REQ-032 Backpressure: dout_rdy=0, send 0x3C then 0xC3 -> dout holds 0x3C, overrun pulses at 0xC3 completion; dout_rdy=1 then delivers 0x3C only.
REQ-033 Drain/complete collision: 0x3C held, dout_rdy rises in 0xC3 completion cycle -> 0x3C accepted, dout=0xC3 valid next cycle, no overrun.
REQ-034 Reset mid-word: rst_n low after 4 bits -> all outputs 0 immediately; after release, 5 bits without sof -> no dout_vld; then sof + 0x01 -> dout=0x01.
